median_window_sched: RTL

// Scheduler/controller for the serial 9-sample median unit (MEDIAN) in the video filter path.

---
 rtl/median_window_sched.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/median_window_sched.sv
// 3x3 window scheduler for a serial 9-sample median unit; accept to PX_VO = 1 + 9 + median latency cycles.
// PX_RDY low for a whole job; output held in OUT until PX_RDYI, a missing median result falls back to the centre pixel.
module median_window_sched #(
    parameter int NBITS   = 8,
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [NBITS-1:0] PX_I,
    input  logic             PX_VI,
    input  logic             PX_SOF,
    output logic             PX_RDY,
    output logic [NBITS-1:0] PX_O,
    output logic             PX_VO,
    input  logic             PX_RDYI,
    output logic [NBITS-1:0] M_DI,
    output logic             M_DSI,
    input  logic [NBITS-1:0] M_DO,
    input  logic             M_DSO,
    output logic             TMO_ERR
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0]       state;
    logic             rdy_en;
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic [3:0]       cnt;
    logic [TW-1:0]    tmo_cnt;
    logic             armed;

    logic [NBITS-1:0] lb0 [WIDTH];
    logic [NBITS-1:0] lb1 [WIDTH];
    // Row-major 3x3 window: 0..2 top row, 3..5 middle, 6..8 bottom; right column is newest.
    logic [NBITS-1:0] win [9];

    logic             accept;
    logic [XW-1:0]    cur_x;
    logic [YW-1:0]    cur_y;
    logic             job_start;

    assign accept    = PX_VI && PX_RDY;
    assign cur_x     = PX_SOF ? '0 : x;
    assign cur_y     = PX_SOF ? '0 : y;
    assign job_start = (cur_x >= XW'(2)) && (cur_y >= YW'(2));

    assign PX_RDY = rdy_en && (state == S_IDLE);
    assign PX_VO  = (state == S_OUT);
    assign M_DSI  = (state == S_SEND);
    assign M_DI   = M_DSI ? win[cnt] : '0;

    always_ff @(posedge CLK) begin
        if (accept) begin
            lb1[cur_x] <= lb0[cur_x];
            lb0[cur_x] <= PX_I;
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= lb1[cur_x];
            win[3] <= win[4];
            win[4] <= win[5];
            win[5] <= lb0[cur_x];
            win[6] <= win[7];
            win[7] <= win[8];
            win[8] <= PX_I;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= S_IDLE;
            rdy_en  <= 1'b0;
            x       <= '0;
            y       <= '0;
            cnt     <= '0;
            tmo_cnt <= '0;
            armed   <= 1'b0;
            PX_O    <= '0;
            TMO_ERR <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (cur_x == XW'(WIDTH - 1)) begin
                            x <= '0;
                            y <= (cur_y == YW'(HEIGHT - 1)) ? '0 : cur_y + 1'b1;
                        end else begin
                            x <= cur_x + 1'b1;
                            y <= cur_y;
                        end
                        if (PX_SOF)
                            TMO_ERR <= 1'b0;
                        if (job_start) begin
                            state <= S_SEND;
                            cnt   <= '0;
                        end
                    end
                end
                S_SEND: begin
                    if (cnt == 4'd8) begin
                        state   <= S_WAIT;
                        tmo_cnt <= '0;
                        armed   <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    // A result flag still high from the previous job counts only after it has dropped once.
                    if (!M_DSO)
                        armed <= 1'b1;
                    if (M_DSO && armed) begin
                        PX_O  <= M_DO;
                        state <= S_OUT;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        PX_O    <= win[4];
                        TMO_ERR <= 1'b1;
                        state   <= S_OUT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    if (PX_RDYI)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
